elevator_ctrl: RTL and testbench
================================

# elevator_ctrl

Car controller for the elevator: consumes the latched request vectors from the button-latch stage, runs a collective (SCAN) dispatch state machine that moves the car floor by floor, opens the door at serviced floors and returns one-hot clear strobes to the button-latch stage. It sits directly downstream of the button latches and drives the motor and door actuators.

## Interface
- FLOORS, 8, number of floors; must equal the button-latch width; ≥2
- TRAVEL_CYCLES, 16, clock cycles to move one floor; ≥1
- DOOR_CYCLES, 32, clock cycles door stays open per stop; ≥1
- clk  input  1  clock, all state on rising edge
- reset  input  1  asynchronous, active-low
- active_in_levels  input  FLOORS  latched car-panel requests
- active_out_up_levels  input  FLOORS  latched hall up requests
- active_out_down_levels  input  FLOORS  latched hall down requests
- inactive_in_levels  output  FLOORS  clear strobes to car-panel latches, registered
- inactive_out_up_levels  output  FLOORS  clear strobes to hall up latches, registered
- inactive_out_down_levels  output  FLOORS  clear strobes to hall down latches, registered
- floor  output  $clog2(FLOORS)  current car floor, registered
- dir_up  output  1  current travel direction, 1 = up
- motor_up  output  1  drive up, registered
- motor_down  output  1  drive down, registered
- door_open  output  1  door command, registered

## Operation
- reset (asynchronous, active-low; clock clk): state IDLE, floor 0, dir_up 1, motor_up/motor_down/door_open 0, all inactive_* 0, counter 0. Reset mid-move or mid-door aborts immediately.
- req[f] = in[f] | up[f] | down[f]. ahead = any req strictly beyond floor in dir; behind = any req strictly on other side.
- here (stop condition at floor f, direction d): in[f]; or hall bit matching d; or, if no req ahead, the opposite hall bit (direction flips to it).
- IDLE: here → DOOR. Else ahead → MOVE keeping dir. Else behind → flip dir, MOVE. Else stay IDLE. Requests both above and below: keep current dir.
- MOVE: motor_up = dir_up, motor_down = !dir_up. Counter counts 0..TRAVEL_CYCLES-1; on terminal count floor ±1 and, evaluated on the new floor: here → DOOR; ahead → MOVE (counter 0); else → IDLE. floor never leaves 0..FLOORS-1; a move beyond is impossible by construction and is an assertion failure.
- DOOR: motors 0, door_open 1 for exactly DOOR_CYCLES cycles, then IDLE. Each cycle in DOOR, inactive_in_levels[floor] = 1 and the hall bit for the (possibly flipped) dir at floor = 1; all other strobe bits 0. A press at the same floor during DOOR is re-cleared (latch press priority holds it only while held).
- Top floor: up[FLOORS-1] ignored for stops; bottom: down[0] ignored.

## Timing
- IDLE with here: next edge DOOR, door_open and strobes high; latch clears one edge later.
- IDLE → MOVE: motor asserted the edge after decision; floor changes TRAVEL_CYCLES cycles after motor rises.
- Floor-to-floor pass-through: motor stays high continuously; floor steps every TRAVEL_CYCLES.
- Stop: floor update and DOOR entry on the same edge; motor low from that edge.
- Door: DOOR_CYCLES cycles, then one IDLE cycle minimum before next MOVE or DOOR.
- Strobes valid only in DOOR; zero in IDLE and MOVE.

## Structure
- Package elevator_pkg: state enum (IDLE, MOVE, DOOR), direction constants, default FLOORS/TRAVEL_CYCLES/DOOR_CYCLES.
- Sub-module request_scan (combinational): given request vectors, floor, dir → ahead, behind, here, flip, clear masks. FSM, counter and output registers in elevator_ctrl.

## Test plan
(FLOORS=8, TRAVEL_CYCLES=4, DOOR_CYCLES=6, strobes fed back through a latch model.)
- Reset, in[3] at floor 0 → motor_up 12 cycles, floor 1,2,3 at 4-cycle steps, door_open 6 cycles with inactive_in[3]=1, then IDLE, motors 0.
- in[0] at floor 0 from IDLE → next cycle DOOR, inactive_in[0]=1, no motor activity.
- From floor 0 going to in[5], up[2] and down[3] pressed → stops at 2 (clears up[2] only), passes 3, stops at 5, reverses, stops at 3 clearing down[3], dir_up=0.
- down[7] only, car at 0 → travels to 7, stops, inactive_out_down[7]=1, dir_up=0.
- Car at 3, dir_up=1, in[1] and in[6] → serves 6 first, then 1.
- reset low mid-MOVE at floor 2 → same cycle floor 0, motors 0, door 0, strobes 0; after release with no requests stays IDLE.

Source files
------------

// File: rtl/elevator_pkg.sv
// Shared types and defaults for the elevator car controller.
// Contains the FSM state encoding, direction constants and default parameter values.
package elevator_pkg;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        MOVE = 2'd1,
        DOOR = 2'd2
    } state_t;

    localparam logic DIR_UP   = 1'b1;
    localparam logic DIR_DOWN = 1'b0;

    localparam int DEF_FLOORS        = 8;
    localparam int DEF_TRAVEL_CYCLES = 16;
    localparam int DEF_DOOR_CYCLES   = 32;

endpackage

// File: rtl/elevator_ctrl_request_scan.sv
// Combinational SCAN evaluation of the latched requests at one floor/direction.
// Produces ahead/behind summaries, the stop decision and the one-hot clear masks.
module request_scan
    import elevator_pkg::*;
#(
    parameter int FLOORS = DEF_FLOORS
) (
    input  logic [FLOORS-1:0]         in_levels,
    input  logic [FLOORS-1:0]         up_levels,
    input  logic [FLOORS-1:0]         down_levels,
    input  logic [$clog2(FLOORS)-1:0] floor,
    input  logic                      dir_up,
    output logic                      ahead,
    output logic                      behind,
    output logic                      here,
    output logic                      flip,
    output logic [FLOORS-1:0]         clear_in,
    output logic [FLOORS-1:0]         clear_up,
    output logic [FLOORS-1:0]         clear_down
);

    localparam int FW = $clog2(FLOORS);

    logic [FLOORS-1:0] req;
    logic [FLOORS-1:0] above;
    logic [FLOORS-1:0] below;
    logic [FLOORS-1:0] sel;
    logic              in_here;
    logic              up_here;
    logic              down_here;
    logic              hall_same;
    logic              hall_opp;
    logic              eff_dir;

    assign req = in_levels | up_levels | down_levels;

    genvar gi;
    generate
        for (gi = 0; gi < FLOORS; gi++) begin : g_floor
            assign sel[gi]   = (FW'(gi) == floor);
            assign above[gi] = req[gi] && (FW'(gi) > floor);
            assign below[gi] = req[gi] && (FW'(gi) < floor);
        end
    endgenerate

    // Hall up at the top floor and hall down at the bottom never cause a stop.
    assign in_here   = |(in_levels & sel);
    assign up_here   = |(up_levels & sel) & ~sel[FLOORS-1];
    assign down_here = |(down_levels & sel) & ~sel[0];

    assign ahead     = dir_up ? |above : |below;
    assign behind    = dir_up ? |below : |above;
    assign hall_same = dir_up ? up_here : down_here;
    assign hall_opp  = dir_up ? down_here : up_here;

    // Take the opposite hall call only when nothing further on needs us.
    assign flip = hall_opp & ~ahead & ~hall_same;
    assign here = in_here | hall_same | flip;

    assign eff_dir    = dir_up ^ flip;
    assign clear_in   = sel;
    assign clear_up   = eff_dir ? sel : '0;
    assign clear_down = eff_dir ? '0 : sel;

endmodule

// File: rtl/elevator_ctrl.sv
// Elevator car controller: collective (SCAN) dispatch FSM driving motor and door,
// returning registered one-hot clear strobes to the button-latch stage.
module elevator_ctrl
    import elevator_pkg::*;
#(
    parameter int FLOORS        = DEF_FLOORS,
    parameter int TRAVEL_CYCLES = DEF_TRAVEL_CYCLES,
    parameter int DOOR_CYCLES   = DEF_DOOR_CYCLES
) (
    input  logic                      clk,
    input  logic                      reset,
    input  logic [FLOORS-1:0]         active_in_levels,
    input  logic [FLOORS-1:0]         active_out_up_levels,
    input  logic [FLOORS-1:0]         active_out_down_levels,
    output logic [FLOORS-1:0]         inactive_in_levels,
    output logic [FLOORS-1:0]         inactive_out_up_levels,
    output logic [FLOORS-1:0]         inactive_out_down_levels,
    output logic [$clog2(FLOORS)-1:0] floor,
    output logic                      dir_up,
    output logic                      motor_up,
    output logic                      motor_down,
    output logic                      door_open
);

    localparam int FW   = $clog2(FLOORS);
    localparam int MAXC = (TRAVEL_CYCLES > DOOR_CYCLES) ? TRAVEL_CYCLES : DOOR_CYCLES;
    localparam int CW   = $clog2(MAXC + 1);
    localparam logic [CW-1:0] TRAVEL_LAST = CW'(TRAVEL_CYCLES - 1);
    localparam logic [CW-1:0] DOOR_LAST   = CW'(DOOR_CYCLES - 1);

    state_t            state;
    logic [CW-1:0]     cnt;
    logic [FW-1:0]     eval_floor;
    logic              ahead;
    logic              behind;
    logic              here;
    logic              flip;
    logic [FLOORS-1:0] clr_in;
    logic [FLOORS-1:0] clr_up;
    logic [FLOORS-1:0] clr_down;
    logic [FLOORS-1:0] floor_sel;

    // While moving, decisions are taken for the floor being arrived at.
    always_comb begin
        eval_floor = floor;
        if (state == MOVE) begin
            eval_floor = dir_up ? (floor + FW'(1)) : (floor - FW'(1));
        end
    end

    genvar gi;
    generate
        for (gi = 0; gi < FLOORS; gi++) begin : g_sel
            assign floor_sel[gi] = (floor == FW'(gi));
        end
    endgenerate

    request_scan #(
        .FLOORS(FLOORS)
    ) u_scan (
        .in_levels   (active_in_levels),
        .up_levels   (active_out_up_levels),
        .down_levels (active_out_down_levels),
        .floor       (eval_floor),
        .dir_up      (dir_up),
        .ahead       (ahead),
        .behind      (behind),
        .here        (here),
        .flip        (flip),
        .clear_in    (clr_in),
        .clear_up    (clr_up),
        .clear_down  (clr_down)
    );

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state                    <= IDLE;
            cnt                      <= '0;
            floor                    <= '0;
            dir_up                   <= DIR_UP;
            motor_up                 <= 1'b0;
            motor_down               <= 1'b0;
            door_open                <= 1'b0;
            inactive_in_levels       <= '0;
            inactive_out_up_levels   <= '0;
            inactive_out_down_levels <= '0;
        end else begin
            case (state)
                IDLE: begin
                    cnt <= '0;
                    if (here) begin
                        state                    <= DOOR;
                        dir_up                   <= dir_up ^ flip;
                        door_open                <= 1'b1;
                        inactive_in_levels       <= clr_in;
                        inactive_out_up_levels   <= clr_up;
                        inactive_out_down_levels <= clr_down;
                    end else if (ahead) begin
                        state      <= MOVE;
                        motor_up   <= dir_up;
                        motor_down <= ~dir_up;
                    end else if (behind) begin
                        state      <= MOVE;
                        dir_up     <= ~dir_up;
                        motor_up   <= ~dir_up;
                        motor_down <= dir_up;
                    end
                end
                MOVE: begin
                    if (cnt != TRAVEL_LAST) begin
                        cnt <= cnt + CW'(1);
                    end else begin
                        cnt   <= '0;
                        floor <= eval_floor;
                        if (here) begin
                            state                    <= DOOR;
                            dir_up                   <= dir_up ^ flip;
                            motor_up                 <= 1'b0;
                            motor_down               <= 1'b0;
                            door_open                <= 1'b1;
                            inactive_in_levels       <= clr_in;
                            inactive_out_up_levels   <= clr_up;
                            inactive_out_down_levels <= clr_down;
                        end else if (!ahead) begin
                            state      <= IDLE;
                            motor_up   <= 1'b0;
                            motor_down <= 1'b0;
                        end
                    end
                end
                DOOR: begin
                    // Keep clearing every cycle so a press at this floor during the stop is dropped.
                    if (cnt != DOOR_LAST) begin
                        cnt                      <= cnt + CW'(1);
                        inactive_in_levels       <= floor_sel;
                        inactive_out_up_levels   <= dir_up ? floor_sel : '0;
                        inactive_out_down_levels <= dir_up ? '0 : floor_sel;
                    end else begin
                        cnt                      <= '0;
                        state                    <= IDLE;
                        door_open                <= 1'b0;
                        inactive_in_levels       <= '0;
                        inactive_out_up_levels   <= '0;
                        inactive_out_down_levels <= '0;
                    end
                end
                default: begin
                    state <= IDLE;
                end
            endcase
        end
    end

    a_floor_in_range: assert property (@(posedge clk) disable iff (!reset)
        (state == MOVE && cnt == TRAVEL_LAST) |->
            (dir_up ? (floor != FW'(FLOORS - 1)) : (floor != '0)));

endmodule

// File: tb/tb_elevator_ctrl.sv
// Self-checking bench for elevator_ctrl: button latches modelled in the bench,
// expected door stops pushed to a scoreboard queue and popped on each door opening.
module tb_elevator_ctrl;

    localparam int F = 8;
    localparam int T = 4;
    localparam int D = 6;

    typedef struct {
        logic [7:0] in_m;
        logic [7:0] up_m;
        logic [7:0] down_m;
        int         first;
        int         nstop;
        int         fin_fl;
        logic       fin_dir;
        int         motor;
    } vec_t;

    typedef struct {
        int   fl;
        logic dir;
        int   off;
    } stop_t;

    typedef struct {
        int   fl;
        logic dir;
        int   at;
    } exp_t;

    logic       clk = 1'b0;
    logic       reset = 1'b0;
    logic [7:0] press_in = '0, press_up = '0, press_down = '0;
    logic [7:0] lat_in, lat_up, lat_down;
    logic [7:0] inactive_in_levels, inactive_out_up_levels, inactive_out_down_levels;
    logic [2:0] floor;
    logic       dir_up, motor_up, motor_down, door_open;

    int   cyc = 0;
    int   n_checks = 0;
    int   n_fail = 0;
    int   mot_total = 0;
    int   door_run = 0;
    logic door_prev = 1'b0;
    exp_t q[$];

    vec_t  vecs[8];
    stop_t stops[11];

    elevator_ctrl #(
        .FLOORS        (F),
        .TRAVEL_CYCLES (T),
        .DOOR_CYCLES   (D)
    ) dut (
        .clk                      (clk),
        .reset                    (reset),
        .active_in_levels         (lat_in),
        .active_out_up_levels     (lat_up),
        .active_out_down_levels   (lat_down),
        .inactive_in_levels       (inactive_in_levels),
        .inactive_out_up_levels   (inactive_out_up_levels),
        .inactive_out_down_levels (inactive_out_down_levels),
        .floor                    (floor),
        .dir_up                   (dir_up),
        .motor_up                 (motor_up),
        .motor_down               (motor_down),
        .door_open                (door_open)
    );

    always #5 clk = ~clk;

    always @(posedge clk) cyc++;

    // Button latch model: a press wins over a clear strobe in the same cycle.
    always @(posedge clk or negedge reset) begin
        if (!reset) begin
            lat_in   <= '0;
            lat_up   <= '0;
            lat_down <= '0;
        end else begin
            lat_in   <= press_in   | (lat_in   & ~inactive_in_levels);
            lat_up   <= press_up   | (lat_up   & ~inactive_out_up_levels);
            lat_down <= press_down | (lat_down & ~inactive_out_down_levels);
        end
    end

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
        n_checks++;
        if (act !== req) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h, required 0x%0h (cycle %0d)", name, act, req, cyc);
        end
    endtask

    // Output monitor and scoreboard consumer.
    always @(negedge clk) begin
        exp_t       e;
        logic [7:0] one;
        if (motor_up || motor_down) mot_total++;
        if (door_open)
            check("door_motors_off", 32'({motor_up, motor_down}), 32'd0);
        else
            check("strobes_zero_outside_door",
                  32'({inactive_in_levels, inactive_out_up_levels, inactive_out_down_levels}), 32'd0);
        if (door_open && !door_prev) begin
            check("door_expected", 32'(q.size() != 0), 32'd1);
            if (q.size() != 0) begin
                e   = q.pop_front();
                one = 8'd1 << e.fl;
                check("stop_floor", 32'(floor), 32'(e.fl));
                check("stop_dir", 32'(dir_up), 32'(e.dir));
                check("stop_cycle", 32'(cyc), 32'(e.at));
                check("stop_clear_in", 32'(inactive_in_levels), 32'(one));
                check("stop_clear_up", 32'(inactive_out_up_levels), e.dir ? 32'(one) : 32'd0);
                check("stop_clear_down", 32'(inactive_out_down_levels), e.dir ? 32'd0 : 32'(one));
                $display("stop at floor %0d dir_up=%0d cycle %0d", floor, dir_up, cyc);
            end
        end
        if (door_open) begin
            door_run++;
        end else if (door_prev) begin
            check("door_length", 32'(door_run), 32'(D));
            door_run = 0;
        end
        door_prev = door_open;
    end

    task automatic settle();
        logic ok;
        ok = 1'b0;
        for (int i = 0; i < 300 && !ok; i++) begin
            @(negedge clk);
            if (q.size() == 0 && !door_open && !motor_up && !motor_down &&
                lat_in == 8'd0 && lat_up == 8'd0 && lat_down == 8'd0)
                ok = 1'b1;
        end
        check("settle_in_time", 32'(ok), 32'd1);
        if (!ok) q.delete();
        repeat (3) @(negedge clk);
    endtask

    initial begin
        int   c0;
        int   mstart;
        int   k;
        int   activity;
        logic found;
        exp_t e;

        stops[0]  = '{0, 1'b1, 2};
        stops[1]  = '{3, 1'b1, 14};
        stops[2]  = '{6, 1'b1, 14};
        stops[3]  = '{1, 1'b0, 41};
        stops[4]  = '{0, 1'b0, 6};
        stops[5]  = '{2, 1'b1, 10};
        stops[6]  = '{5, 1'b1, 29};
        stops[7]  = '{3, 1'b0, 44};
        stops[8]  = '{0, 1'b0, 14};
        stops[9]  = '{7, 1'b0, 30};
        stops[10] = '{0, 1'b0, 30};
        vecs[0] = '{8'h01, 8'h00, 8'h00, 0,  1, 0, 1'b1, 0};
        vecs[1] = '{8'h08, 8'h00, 8'h00, 1,  1, 3, 1'b1, 12};
        vecs[2] = '{8'h42, 8'h00, 8'h00, 2,  2, 1, 1'b0, 32};
        vecs[3] = '{8'h01, 8'h00, 8'h00, 4,  1, 0, 1'b0, 4};
        vecs[4] = '{8'h20, 8'h04, 8'h08, 5,  3, 3, 1'b0, 28};
        vecs[5] = '{8'h01, 8'h00, 8'h00, 8,  1, 0, 1'b0, 12};
        vecs[6] = '{8'h00, 8'h00, 8'h80, 9,  1, 7, 1'b0, 28};
        vecs[7] = '{8'h01, 8'h00, 8'h00, 10, 1, 0, 1'b0, 28};

        repeat (3) @(negedge clk);
        check("reset_floor", 32'(floor), 32'd0);
        check("reset_dir", 32'(dir_up), 32'd1);
        check("reset_motors", 32'({motor_up, motor_down}), 32'd0);
        check("reset_door", 32'(door_open), 32'd0);
        reset = 1'b1;
        repeat (2) @(negedge clk);

        for (int v = 0; v < 8; v++) begin
            mstart = mot_total;
            @(negedge clk);
            c0 = cyc;
            press_in   = vecs[v].in_m;
            press_up   = vecs[v].up_m;
            press_down = vecs[v].down_m;
            for (int s = 0; s < vecs[v].nstop; s++) begin
                k    = vecs[v].first + s;
                e.fl = stops[k].fl;
                e.dir = stops[k].dir;
                e.at = c0 + stops[k].off;
                q.push_back(e);
            end
            @(negedge clk);
            press_in = '0; press_up = '0; press_down = '0;
            settle();
            check("final_floor", 32'(floor), 32'(vecs[v].fin_fl));
            check("final_dir", 32'(dir_up), 32'(vecs[v].fin_dir));
            check("motor_cycles", 32'(mot_total - mstart), 32'(vecs[v].motor));
            $display("vector %0d: in=%02h up=%02h down=%02h -> floor %0d dir_up %0d motor %0d",
                     v, vecs[v].in_m, vecs[v].up_m, vecs[v].down_m, floor, dir_up, mot_total - mstart);
        end

        // Same-floor press during an open door is re-cleared and does not reopen it.
        mstart = mot_total;
        @(negedge clk);
        c0 = cyc;
        press_in = 8'h01;
        e.fl = 0; e.dir = 1'b0; e.at = c0 + 2;
        q.push_back(e);
        @(negedge clk);
        press_in = '0;
        repeat (2) @(negedge clk);
        press_in = 8'h01;
        @(negedge clk);
        press_in = '0;
        settle();
        check("reclear_motor_cycles", 32'(mot_total - mstart), 32'd0);
        check("reclear_floor", 32'(floor), 32'd0);
        $display("re-clear during door: floor %0d latch %02h", floor, lat_in);

        // Asynchronous reset in the middle of a move.
        @(negedge clk);
        press_in = 8'h40;
        @(negedge clk);
        press_in = '0;
        found = 1'b0;
        for (int i = 0; i < 100 && !found; i++) begin
            @(negedge clk);
            if (floor == 3'd2) found = 1'b1;
        end
        check("reach_floor2", 32'(found), 32'd1);
        @(negedge clk);
        check("pass_through_motor", 32'(motor_up), 32'd1);
        reset = 1'b0;
        #1;
        check("midmove_reset_floor", 32'(floor), 32'd0);
        check("midmove_reset_motors", 32'({motor_up, motor_down}), 32'd0);
        check("midmove_reset_door", 32'(door_open), 32'd0);
        check("midmove_reset_strobes",
              32'({inactive_in_levels, inactive_out_up_levels, inactive_out_down_levels}), 32'd0);
        check("midmove_reset_dir", 32'(dir_up), 32'd1);
        repeat (2) @(negedge clk);
        reset = 1'b1;
        activity = 0;
        for (int i = 0; i < 20; i++) begin
            @(negedge clk);
            if (motor_up || motor_down || door_open || floor != 3'd0) activity++;
        end
        check("idle_after_reset", 32'(activity), 32'd0);
        $display("reset mid-move: floor %0d, idle cycles with activity %0d", floor, activity);

        check("queue_drained", 32'(q.size()), 32'd0);
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
